// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared encodings for the RV32I multi-cycle control path
package rv_ctrl_pkg;

  // Major opcodes, IR[6:0]
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  // ALUOp handed to the ALU control block
  localparam logic [2:0] ALUOP_R    = 3'b000;
  localparam logic [2:0] ALUOP_I    = 3'b001;
  localparam logic [2:0] ALUOP_ADD  = 3'b010;
  localparam logic [2:0] ALUOP_B    = 3'b011;
  localparam logic [2:0] ALUOP_U    = 3'b100;
  localparam logic [2:0] ALUOP_J    = 3'b101;
  localparam logic [2:0] ALUOP_LOAD = 3'b110;
  localparam logic [2:0] ALUOP_JALR = 3'b111;

  // Sequencer states; 6 and 7 are unused and recover to IF
  localparam logic [2:0] ST_IF   = 3'd0;
  localparam logic [2:0] ST_ID   = 3'd1;
  localparam logic [2:0] ST_EX   = 3'd2;
  localparam logic [2:0] ST_MEM  = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;
  localparam logic [2:0] ST_HALT = 3'd5;

  // Datapath mux selects
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCA_ZERO   = 2'b11;
  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] MTR_ALUOUT  = 2'b00;
  localparam logic [1:0] MTR_MDR     = 2'b01;
  localparam logic [1:0] MTR_LINK    = 2'b10;
  localparam logic [1:0] PCS_ALU     = 2'b00;
  localparam logic [1:0] PCS_ALUOUT  = 2'b01;
  localparam logic [1:0] PCS_JALR    = 2'b10;

  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_SYS,
    CLS_ILLEGAL
  } instr_class_t;

endpackage

// File: rtl/rv_opcode_class.sv
// rtl/rv_opcode_class.sv - combinational opcode to instruction-class decoder
module rv_opcode_class
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [3:0] iclass
);

  // Map the major opcode onto one instruction class; unknown opcodes are illegal
  always_comb begin
    iclass = CLS_ILLEGAL;
    case (opcode)
      OP_R:      iclass = CLS_R;
      OP_I:      iclass = CLS_I;
      OP_LOAD:   iclass = CLS_LOAD;
      OP_STORE:  iclass = CLS_STORE;
      OP_BRANCH: iclass = CLS_BRANCH;
      OP_LUI:    iclass = CLS_LUI;
      OP_AUIPC:  iclass = CLS_AUIPC;
      OP_JAL:    iclass = CLS_JAL;
      OP_JALR:   iclass = CLS_JALR;
      OP_SYS:    iclass = CLS_SYS;
      default:   iclass = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - RV32I multi-cycle sequencer; RV_INSTRET_CNT_EN adds a retired-instruction counter
module multicycle_ctrl_fsm
  import rv_ctrl_pkg::*;
#(
  parameter logic [2:0] RESET_STATE = ST_IF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic [2:0] ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] MemtoReg,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       halted
`ifdef RV_INSTRET_CNT_EN
  ,
  output logic [31:0] instret
`endif
);

  logic [2:0]   state;
  logic [2:0]   state_next;
  instr_class_t cls_q;
  instr_class_t id_cls;
  logic [3:0]   id_cls_raw;

  rv_opcode_class u_opcode_class (
    .opcode (opcode),
    .iclass (id_cls_raw)
  );

  assign id_cls = instr_class_t'(id_cls_raw);

  // State register; the class is captured once in ID and held for the rest of the instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RESET_STATE;
      cls_q <= CLS_NOP;
    end else begin
      state <= state_next;
      if (state == ST_ID) cls_q <= id_cls;
    end
  end

  // Next-state selection; unused encodings fall back to IF
  always_comb begin
    state_next = ST_IF;
    case (state)
      ST_IF:   state_next = mem_ready ? ST_ID : ST_IF;
      ST_ID:   state_next = (id_cls == CLS_SYS || id_cls == CLS_ILLEGAL) ? ST_HALT : ST_EX;
      ST_EX: begin
        case (cls_q)
          CLS_LOAD, CLS_STORE: state_next = ST_MEM;
          CLS_R, CLS_I, CLS_LUI, CLS_AUIPC,
          CLS_JAL, CLS_JALR:   state_next = ST_WB;
          default:             state_next = ST_IF;
        endcase
      end
      ST_MEM: begin
        if (!mem_ready)            state_next = ST_MEM;
        else if (cls_q == CLS_LOAD) state_next = ST_WB;
        else                       state_next = ST_IF;
      end
      ST_WB:   state_next = ST_IF;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IF;
    endcase
  end

  // Datapath controls; reset forces everything quiet so an in-flight access is dropped
  always_comb begin
    ALUOp    = ALUOP_ADD;
    ALUSrcA  = SRCA_PC;
    ALUSrcB  = SRCB_RS2;
    MemtoReg = MTR_ALUOUT;
    PCSource = PCS_ALU;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    halted   = 1'b0;
    if (!reset) begin
      case (state)
        ST_IF: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        ST_ID: begin
          // Branch/JAL target is precomputed into ALUOut here
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
        end
        ST_EX: begin
          case (cls_q)
            CLS_R:      begin ALUSrcA = SRCA_RS1;   ALUSrcB = SRCB_RS2; ALUOp = ALUOP_R;    end
            CLS_I:      begin ALUSrcA = SRCA_RS1;   ALUSrcB = SRCB_IMM; ALUOp = ALUOP_I;    end
            CLS_LOAD:   begin ALUSrcA = SRCA_RS1;   ALUSrcB = SRCB_IMM; ALUOp = ALUOP_LOAD; end
            CLS_STORE:  begin ALUSrcA = SRCA_RS1;   ALUSrcB = SRCB_IMM; ALUOp = ALUOP_ADD;  end
            CLS_BRANCH: begin
              ALUSrcA  = SRCA_RS1;
              ALUSrcB  = SRCB_RS2;
              ALUOp    = ALUOP_B;
              PCSource = PCS_ALUOUT;
              PCWrite  = branch_taken;
            end
            CLS_LUI:    begin ALUSrcA = SRCA_ZERO;  ALUSrcB = SRCB_IMM; ALUOp = ALUOP_U;    end
            CLS_AUIPC:  begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; ALUOp = ALUOP_U;    end
            CLS_JAL:    begin ALUOp = ALUOP_J; PCSource = PCS_ALUOUT; PCWrite = 1'b1;       end
            CLS_JALR: begin
              ALUSrcA  = SRCA_RS1;
              ALUSrcB  = SRCB_IMM;
              ALUOp    = ALUOP_JALR;
              PCSource = PCS_JALR;
              PCWrite  = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          IorD     = 1'b1;
          MemRead  = (cls_q == CLS_LOAD);
          MemWrite = (cls_q == CLS_STORE);
        end
        ST_WB: begin
          RegWrite = 1'b1;
          if (cls_q == CLS_LOAD)                          MemtoReg = MTR_MDR;
          else if (cls_q == CLS_JAL || cls_q == CLS_JALR) MemtoReg = MTR_LINK;
          else                                            MemtoReg = MTR_ALUOUT;
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef RV_INSTRET_CNT_EN
  logic retire;

  assign retire = (state == ST_WB) ||
                  (state == ST_MEM && mem_ready && cls_q == CLS_STORE) ||
                  (state == ST_EX && cls_q == CLS_BRANCH);

  // Retired-instruction counter, free-running with natural wrap
  always_ff @(posedge clk) begin
    if (reset)       instret <= 32'd0;
    else if (retire) instret <= instret + 32'd1;
  end
`else
  // Retirement is not tracked in this build
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - self-checking bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       branch_taken;
  logic [2:0] ALUOp;
  logic [1:0] ALUSrcA, ALUSrcB, MemtoReg, PCSource;
  logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, RegWrite, halted;
`ifdef RV_INSTRET_CNT_EN
  logic [31:0] instret;
  logic [31:0] exp_instret = 32'd0;
`endif

  multicycle_ctrl_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .ALUOp        (ALUOp),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .MemtoReg     (MemtoReg),
    .PCSource     (PCSource),
    .IorD         (IorD),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .PCWrite      (PCWrite),
    .RegWrite     (RegWrite),
    .halted       (halted)
`ifdef RV_INSTRET_CNT_EN
    ,
    .instret      (instret)
`endif
  );

  int errors = 0;
  int checks = 0;
  logic prev_irw = 1'b0;
  logic prev_rw  = 1'b0;

  localparam int PH_IF = 0, PH_ID = 1, PH_EX = 2, PH_MEM = 3, PH_WB = 4, PH_HALT = 5, PH_RST = 6;
  localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4, K_LUI = 5,
                 K_AUIPC = 6, K_JAL = 7, K_JALR = 8, K_STOP = 9;

  logic [6:0] legal_ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011};

  logic [17:0] obs;
  assign obs = {ALUOp, ALUSrcA, ALUSrcB, MemtoReg, PCSource, IorD,
                MemRead, MemWrite, IRWrite, PCWrite, RegWrite, halted};

  function automatic int kind_of(input logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b1100011: return K_BR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      default:    return K_STOP;
    endcase
  endfunction

  task automatic retire();
`ifdef RV_INSTRET_CNT_EN
    exp_instret = exp_instret + 32'd1;
`endif
  endtask

  task automatic model_reset();
`ifdef RV_INSTRET_CNT_EN
    exp_instret = 32'd0;
`endif
  endtask

  // One clock cycle: drive inputs, build the expected controls from the phase, compare, advance
  task automatic step(input int ph, input int kind, input logic mr, input logic bt, input string name);
    logic [2:0] aop;
    logic [1:0] sa, sb, mtr, pcs;
    logic iord, mrd, mwr, irw, pcw, rw, hlt;
    logic c_aop, c_sa, c_sb, c_mtr, c_pcs, c_iord;
    logic [17:0] e, m;
    aop = 3'b010; sa = 2'b00; sb = 2'b00; mtr = 2'b00; pcs = 2'b00;
    iord = 0; mrd = 0; mwr = 0; irw = 0; pcw = 0; rw = 0; hlt = 0;
    c_aop = 0; c_sa = 0; c_sb = 0; c_mtr = 0; c_pcs = 0; c_iord = 0;
    mem_ready = mr;
    branch_taken = bt;
    case (ph)
      PH_RST: begin
        c_aop = 1; c_sa = 1; c_sb = 1; c_mtr = 1; c_pcs = 1; c_iord = 1;
      end
      PH_IF: begin
        mrd = 1; sb = 2'b01; irw = mr; pcw = mr;
        c_aop = 1; c_sa = 1; c_sb = 1; c_pcs = 1; c_iord = 1;
      end
      PH_ID: begin
        sa = 2'b01; sb = 2'b10; c_aop = 1; c_sa = 1; c_sb = 1;
      end
      PH_EX: begin
        c_aop = 1; c_sa = 1; c_sb = 1;
        case (kind)
          K_R:     begin sa = 2'b10; sb = 2'b00; aop = 3'b000; end
          K_I:     begin sa = 2'b10; sb = 2'b10; aop = 3'b001; end
          K_LOAD:  begin sa = 2'b10; sb = 2'b10; aop = 3'b110; end
          K_STORE: begin sa = 2'b10; sb = 2'b10; aop = 3'b010; end
          K_BR:    begin sa = 2'b10; sb = 2'b00; aop = 3'b011; pcw = bt; pcs = 2'b01; c_pcs = 1; end
          K_LUI:   begin sa = 2'b11; sb = 2'b10; aop = 3'b100; end
          K_AUIPC: begin sa = 2'b01; sb = 2'b10; aop = 3'b100; end
          K_JAL:   begin aop = 3'b101; pcw = 1; pcs = 2'b01; c_pcs = 1; c_sa = 0; c_sb = 0; end
          default: begin sa = 2'b10; sb = 2'b10; aop = 3'b111; pcw = 1; pcs = 2'b10; c_pcs = 1; end
        endcase
      end
      PH_MEM: begin
        iord = 1; c_iord = 1; mrd = (kind == K_LOAD); mwr = (kind == K_STORE);
      end
      PH_WB: begin
        rw = 1; c_mtr = 1;
        mtr = (kind == K_LOAD) ? 2'b01 : (kind == K_JAL || kind == K_JALR) ? 2'b10 : 2'b00;
      end
      default: hlt = 1;
    endcase
    e = {aop, sa, sb, mtr, pcs, iord, mrd, mwr, irw, pcw, rw, hlt};
    m = {{3{c_aop}}, {2{c_sa}}, {2{c_sb}}, {2{c_mtr}}, {2{c_pcs}}, c_iord, 6'b111111};
    #1;
    checks++;
    if ((obs & m) !== (e & m)) begin
      errors++;
      $display("FAIL %s: controls=%h required=%h (care mask %h)", name, obs, e, m);
    end
    checks++;
    if ((prev_irw && IRWrite) || (prev_rw && RegWrite)) begin
      errors++;
      $display("FAIL %s_no_repeat: IRWrite=%b RegWrite=%b required no repeat of previous cycle", name, IRWrite, RegWrite);
    end
    prev_irw = IRWrite;
    prev_rw  = RegWrite;
`ifdef RV_INSTRET_CNT_EN
    checks++;
    if (instret !== exp_instret) begin
      errors++;
      $display("FAIL %s_instret: instret=%0d required=%0d", name, instret, exp_instret);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  // Complete instruction from fetch to retirement (or halt followed by a recovering reset)
  task automatic run_instr(input logic [6:0] op, input int if_st, input int mem_st, input logic bt);
    int k;
    k = kind_of(op);
    opcode = 7'($urandom);
    for (int i = 0; i < if_st; i++) step(PH_IF, k, 1'b0, 1'($urandom), "if_stall");
    step(PH_IF, k, 1'b1, 1'($urandom), "if_fetch");
    opcode = op;
    step(PH_ID, k, 1'($urandom), 1'($urandom), "id");
    if (k == K_STOP) begin
      for (int i = 0; i < 3; i++) step(PH_HALT, k, 1'($urandom), 1'($urandom), "halt");
      reset = 1'b1;
      step(PH_RST, k, 1'($urandom), 1'($urandom), "halt_reset");
      reset = 1'b0;
      model_reset();
      return;
    end
    step(PH_EX, k, 1'($urandom), bt, "ex");
    if (k == K_BR) begin
      retire();
    end else if (k == K_LOAD || k == K_STORE) begin
      for (int i = 0; i < mem_st; i++) step(PH_MEM, k, 1'b0, 1'($urandom), "mem_stall");
      step(PH_MEM, k, 1'b1, 1'($urandom), "mem_done");
      if (k == K_LOAD) step(PH_WB, k, 1'($urandom), 1'($urandom), "wb");
      retire();
    end else begin
      step(PH_WB, k, 1'($urandom), 1'($urandom), "wb");
      retire();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    opcode = 7'd0;
    step(PH_RST, K_R, 1'b0, 1'b0, "reset_initial");
    step(PH_RST, K_R, 1'b1, 1'b0, "reset_initial");
    reset = 1'b0;
    model_reset();
    step(PH_IF, K_STORE, 1'b1, 1'b0, "rst_if");
    opcode = 7'b0100011;
    step(PH_ID, K_STORE, 1'b0, 1'b0, "rst_id");
    step(PH_EX, K_STORE, 1'b0, 1'b0, "rst_ex");
    step(PH_MEM, K_STORE, 1'b0, 1'b0, "rst_mem_write_held");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(PH_RST, K_STORE, 1'($urandom), 1'b0, "reset_mid_mem");
    reset = 1'b0;
    model_reset();
    step(PH_IF, K_STORE, 1'b0, 1'b0, "post_reset_if");
  endtask

  task automatic test_add();
    run_instr(7'b0110011, 0, 0, 1'b0);
  endtask

  task automatic test_load_stall();
    run_instr(7'b0000011, 0, 2, 1'b0);
  endtask

  task automatic test_branch();
    run_instr(7'b1100011, 0, 0, 1'b1);
    run_instr(7'b1100011, 1, 0, 1'b0);
  endtask

  task automatic test_jalr();
    run_instr(7'b1100111, 0, 0, 1'b0);
    run_instr(7'b1101111, 0, 0, 1'b0);
  endtask

  task automatic test_halt();
    run_instr(7'b0110011, 0, 0, 1'b0);
    run_instr(7'b1111111, 0, 0, 1'b0);
    run_instr(7'b1110011, 1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [6:0] op;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) op = 7'($urandom);
      else                           op = legal_ops[$urandom_range(0, 9)];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    branch_taken = 1'b0;
    opcode = 7'd0;
    test_reset();
    test_add();
    test_load_stall();
    test_branch();
    test_jalr();
    test_halt();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
